// File: rtl/frame_dma_reader.sv
// AXI4 burst-read master that streams one frame from memory into the framebuffer write port.
// Build with FRAME_DMA_PERF_EN defined to get the o_cycles transfer-duration counter.
//
// state | meaning
// IDLE  | waiting for i_start
// ADDR  | AR request presented, held until ARREADY
// DATA  | accepting R beats of the current burst
// DONE  | frame finished, o_done pulses on the following cycle
module frame_dma_reader #(
    parameter int C_M_AXI_ID_WIDTH   = 2,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int N_ROWS_MAX         = 64,
    parameter int N_COLS_MAX         = 256,
    parameter int BURST_LEN          = 16,
    parameter int MEM_W_ADDR_WIDTH   = $clog2(N_ROWS_MAX*N_COLS_MAX)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [MEM_W_ADDR_WIDTH:0]       i_n_pixels,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_err,
    output logic [31:0]                     o_cycles,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARLOCK,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic [3:0]                      M_AXI_ARQOS,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    output logic                            o_we,
    output logic [MEM_W_ADDR_WIDTH-1:0]     o_waddr,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   o_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] o_wstrb
);

    localparam int N_PIX_MAX = N_ROWS_MAX * N_COLS_MAX;
    localparam int CNT_W     = MEM_W_ADDR_WIDTH + 1;
    localparam int AW        = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
    state_t state, next_state;

    logic [AW-1:0]               base;
    logic [MEM_W_ADDR_WIDTH-1:0] word_idx;
    logic [CNT_W-1:0]            remaining;
    logic [CNT_W-1:0]            n_clamped;
    logic [8:0]                  beat_cnt;
    logic [8:0]                  burst_beats;
    logic [AW-1:0]               addr_calc;
    logic [10:0]                 page_words;
    logic [8:0]                  beats_calc;
    logic                        start_ok;
    logic                        beat;
    logic                        beat_ok;
    logic                        last_beat;

    assign start_ok  = (state == IDLE) && i_start;
    assign beat      = (state == DATA) && M_AXI_RVALID;
    assign beat_ok   = (M_AXI_RRESP == 2'b00) && (M_AXI_RID == '0);
    assign last_beat = beat && ((beat_cnt + 9'd1) == burst_beats);
    assign n_clamped = (32'(i_n_pixels) > N_PIX_MAX) ? CNT_W'(N_PIX_MAX) : i_n_pixels;

    assign addr_calc  = base + (AW'(word_idx) << 2);
    // words left before the next 4 KB boundary; AXI bursts must not cross it
    assign page_words = 11'd1024 - {1'b0, addr_calc[11:2]};

    always_comb begin
        beats_calc = 9'(BURST_LEN);
        if (32'(remaining) < 32'(beats_calc))
            beats_calc = 9'(remaining);
        if (32'(page_words) < 32'(beats_calc))
            beats_calc = 9'(page_words);
    end

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARVALID = (state == ADDR);
    assign M_AXI_ARADDR  = (state == ADDR) ? addr_calc : '0;
    assign M_AXI_ARLEN   = (state == ADDR) ? 8'(beats_calc - 9'd1) : 8'd0;
    assign M_AXI_RREADY  = (state == DATA);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_start)
                    next_state = (n_clamped == '0) ? DONE : ADDR;
            end
            ADDR: begin
                if (M_AXI_ARREADY)
                    next_state = DATA;
            end
            DATA: begin
                if (last_beat)
                    next_state = (remaining == CNT_W'(1)) ? DONE : ADDR;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base        <= '0;
            word_idx    <= '0;
            remaining   <= '0;
            beat_cnt    <= '0;
            burst_beats <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_we        <= 1'b0;
            o_waddr     <= '0;
            o_wdata     <= '0;
            o_wstrb     <= '0;
        end else begin
            o_we   <= 1'b0;
            o_wstrb <= '0;
            o_done <= (state == DONE);
            o_busy <= (next_state != IDLE);
            if (start_ok) begin
                base      <= i_base_addr & ~AW'(3);
                word_idx  <= '0;
                remaining <= n_clamped;
                o_err     <= 1'b0;
            end
            if ((state == ADDR) && M_AXI_ARREADY) begin
                burst_beats <= beats_calc;
                beat_cnt    <= '0;
            end
            if (beat) begin
                word_idx  <= word_idx + MEM_W_ADDR_WIDTH'(1);
                remaining <= remaining - CNT_W'(1);
                beat_cnt  <= beat_cnt + 9'd1;
                // errored beats are dropped but still consume their framebuffer slot
                if (beat_ok) begin
                    o_we    <= 1'b1;
                    o_waddr <= word_idx;
                    o_wdata <= M_AXI_RDATA;
                    o_wstrb <= '1;
                end else begin
                    o_err <= 1'b1;
                end
                if (M_AXI_RLAST != last_beat)
                    o_err <= 1'b1;
            end
        end
    end

`ifdef FRAME_DMA_PERF_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt  <= '0;
            o_cycles <= '0;
        end else begin
            if (start_ok)
                cyc_cnt <= '0;
            else if (o_busy && (cyc_cnt != 32'hFFFF_FFFF))
                cyc_cnt <= cyc_cnt + 32'd1;
            if (state == DONE)
                o_cycles <= cyc_cnt;
        end
    end
`else
    assign o_cycles = '0;
`endif

endmodule
